// File: rtl/rsa_host_pkg.sv
// rsa_host_pkg: shared definitions for the RSA host initiator.
//   - OPW          : operand / result width (512 bits)
//   - cmd_e        : protocol command codes carried in arm_to_fpga_cmd[2:0]
//   - state_e      : initiator FSM encoding
//   - step_t/STEP_*: index of the five-step command sequence
//   - step_code()  : command code issued for a given step and job mode
package rsa_host_pkg;

  localparam int OPW   = 512;
  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    COMPUTE_EXP  = 3'd0,
    COMPUTE_MONT = 3'd1,
    READ_MOD     = 3'd2,
    READ_RSQ     = 3'd3,
    READ_EXP     = 3'd4,
    WRITE_EXP    = 3'd5
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RDY,
    S_SEND,
    S_WAIT_RES,
    S_RECV,
    S_WAIT_DONE,
    S_ACK,
    S_WAIT_DONE_LOW,
    S_FINISH,
    S_ERROR
  } state_e;

  typedef logic [2:0] step_t;

  localparam step_t STEP_MOD = 3'd0;  // load modulus
  localparam step_t STEP_RSQ = 3'd1;  // load R^2 mod m and x
  localparam step_t STEP_EXP = 3'd2;  // load exponent and R mod m
  localparam step_t STEP_CMP = 3'd3;  // compute
  localparam step_t STEP_WR  = 3'd4;  // read back result

  function automatic cmd_e step_code(input step_t step, input logic mode);
    cmd_e code;
    case (step)
      STEP_MOD: code = READ_MOD;
      STEP_RSQ: code = READ_RSQ;
      STEP_EXP: code = READ_EXP;
      STEP_CMP: code = mode ? COMPUTE_MONT : COMPUTE_EXP;
      default:  code = WRITE_EXP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rsa_host_watchdog.sv
// rsa_host_watchdog: wait-state timeout counter for the RSA host initiator.
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   clear_i   : restart the count (asserted on every FSM state change)
//   enable_i  : count while the FSM sits in a wait state
//   expired_o : counter is all-ones while enabled
module rsa_host_watchdog #(
  parameter int W = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired_o = enable_i && (&cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rsa_host_initiator.sv
// rsa_host_initiator: on-chip stand-in for the Arm side of the RSA core
// wrapper protocol. Latches one job, issues READ_MOD, READ_RSQ, READ_EXP,
// COMPUTE_EXP/COMPUTE_MONT and WRITE_EXP in order, and returns the 512-bit
// result to the local client.
//
// Optional build macro: RSA_HOST_INIT_WATCHDOG_EN adds a TIMEOUT_W-bit wait
// state watchdog that drops the job into ERROR. Without it `error` is 0.
//
// Ports
//   clk, reset              : clock / asynchronous active-high reset
//   start, mode, operands   : job request (sampled when start is accepted)
//   busy                    : job in flight
//   result, result_valid    : returned result and its one-cycle update pulse
//   error                   : watchdog fired (sticky until next start)
//   arm_to_fpga_cmd(_valid) : command word and strobe
//   fpga_to_arm_done(_read) : responder done level and its acknowledge
//   arm_to_fpga_data*       : operand payload, strobe, responder ready
//   fpga_to_arm_data*       : result bus, offer, accept
module rsa_host_initiator
  import rsa_host_pkg::*;
#(
  parameter int TX_SIZE   = 1024,
  parameter int TIMEOUT_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [OPW-1:0]     modulus,
  input  logic [OPW-1:0]     rmodm,
  input  logic [OPW-1:0]     rsqmodm,
  input  logic [OPW-1:0]     exponent,
  input  logic [OPW-1:0]     x,
  output logic               busy,
  output logic [OPW-1:0]     result,
  output logic               result_valid,
  output logic               error,
  output logic [31:0]        arm_to_fpga_cmd,
  output logic               arm_to_fpga_cmd_valid,
  input  logic               fpga_to_arm_done,
  output logic               fpga_to_arm_done_read,
  output logic               arm_to_fpga_data_valid,
  input  logic               arm_to_fpga_data_ready,
  output logic [TX_SIZE-1:0] arm_to_fpga_data,
  input  logic               fpga_to_arm_data_valid,
  output logic               fpga_to_arm_data_ready,
  input  logic [TX_SIZE-1:0] fpga_to_arm_data
);

  state_e state_q, state_d;
  step_t  step_q, step_d;
  logic   accept;
  logic   wd_expired;

  logic           mode_q;
  logic [OPW-1:0] modulus_q, rmodm_q, rsqmodm_q, exponent_q, x_q;
  logic [OPW-1:0] res_buf_q;
  logic [OPW-1:0] result_q;
  logic           result_valid_q;
  logic           busy_q;
  logic           cmd_valid_q;
  logic           data_valid_q;
  logic           res_ready_q;
  logic           done_read_q;
  cmd_e           cur_code;
  logic [TX_SIZE-1:0] payload;

  // Only the low half of the result bus carries data.
  logic unused_rx_hi;
  assign unused_rx_hi = ^fpga_to_arm_data[TX_SIZE-1:OPW];

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          accept  = 1'b1;
          step_d  = STEP_MOD;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (step_q == STEP_CMP)     state_d = S_WAIT_DONE;
        else if (step_q == STEP_WR) state_d = S_WAIT_RES;
        else                        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (arm_to_fpga_data_ready) state_d = S_SEND;
        else if (wd_expired)        state_d = S_ERROR;
      end
      S_SEND: state_d = S_WAIT_DONE;
      S_WAIT_RES: begin
        if (fpga_to_arm_data_valid) state_d = S_RECV;
        else if (wd_expired)        state_d = S_ERROR;
      end
      S_RECV: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (fpga_to_arm_done) state_d = S_ACK;
        else if (wd_expired)  state_d = S_ERROR;
      end
      S_ACK: state_d = S_WAIT_DONE_LOW;
      S_WAIT_DONE_LOW: begin
        // Done must fall before the next step so one done level is never
        // counted twice.
        if (!fpga_to_arm_done) begin
          if (step_q == STEP_WR) begin
            state_d = S_FINISH;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else if (wd_expired) begin
          state_d = S_ERROR;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- state and data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      step_q     <= STEP_MOD;
      mode_q     <= 1'b0;
      modulus_q  <= '0;
      rmodm_q    <= '0;
      rsqmodm_q  <= '0;
      exponent_q <= '0;
      x_q        <= '0;
      res_buf_q  <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (accept) begin
        mode_q     <= mode;
        modulus_q  <= modulus;
        rmodm_q    <= rmodm;
        rsqmodm_q  <= rsqmodm;
        exponent_q <= exponent;
        x_q        <= x;
      end
      // The ready/valid handshake completes at the edge that leaves RECV.
      if (state_q == S_RECV) begin
        res_buf_q <= fpga_to_arm_data[OPW-1:0];
      end
      // The client-visible result only changes together with result_valid,
      // so a job aborted by reset or timeout never exposes a partial result.
      if (state_d == S_FINISH) begin
        result_q <= res_buf_q;
      end
    end
  end

  // Strobes are registered from the next state, so each is high exactly for
  // the one cycle the FSM spends in its state and no two can overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q         <= 1'b0;
      cmd_valid_q    <= 1'b0;
      data_valid_q   <= 1'b0;
      res_ready_q    <= 1'b0;
      done_read_q    <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      busy_q         <= !(state_d inside {S_IDLE, S_FINISH, S_ERROR});
      cmd_valid_q    <= (state_d == S_ISSUE);
      data_valid_q   <= (state_d == S_SEND);
      res_ready_q    <= (state_d == S_RECV);
      done_read_q    <= (state_d == S_ACK);
      result_valid_q <= (state_d == S_FINISH);
    end
  end

  // --------------------------------------------------------- protocol outputs
  // Command word and payload are held for the whole step and forced to zero
  // whenever no job is in flight (IDLE, FINISH, ERROR).
  assign cur_code = step_code(step_q, mode_q);

  always_comb begin
    payload = '0;
    if (busy_q) begin
      case (step_q)
        STEP_MOD: payload = {{OPW{1'b0}}, modulus_q};
        STEP_RSQ: payload = {x_q, rsqmodm_q};
        STEP_EXP: payload = {rmodm_q, exponent_q};
        default:  payload = '0;
      endcase
    end
  end

  assign arm_to_fpga_cmd        = busy_q ? {{(32-CMD_W){1'b0}}, cur_code} : 32'd0;
  assign arm_to_fpga_cmd_valid  = cmd_valid_q;
  assign arm_to_fpga_data       = payload;
  assign arm_to_fpga_data_valid = data_valid_q;
  assign fpga_to_arm_data_ready = res_ready_q;
  assign fpga_to_arm_done_read  = done_read_q;
  assign busy                   = busy_q;
  assign result                 = result_q;
  assign result_valid           = result_valid_q;

  // ------------------------------------------------------------------ watchdog
`ifdef RSA_HOST_INIT_WATCHDOG_EN
  logic state_change;
  logic waiting;
  logic error_q;

  assign state_change = (state_d != state_q);
  assign waiting      = state_q inside {S_WAIT_RDY, S_WAIT_RES, S_WAIT_DONE, S_WAIT_DONE_LOW};

  rsa_host_watchdog #(
    .W(TIMEOUT_W)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_change),
    .enable_i  (waiting),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= (state_d == S_ERROR);
    end
  end

  assign error = error_q;
`else
  localparam int unused_timeout_w = TIMEOUT_W;
  assign wd_expired = 1'b0;
  assign error      = 1'b0;
`endif

endmodule
